// File: rtl/consumer_pipe.sv
// consumer_pipe: C2F chunk consumer with a pipelined buffer read, a 64-bit
// add/XOR checksum and a programmable minimum dwell before the dtAck_out pulse.
// Optional build macro: CONSUMER_CHUNK_COUNT_EN adds chunkCount_out[31:0].
//
// state   | meaning
// S_IDLE  | waiting for wrIndex_in != rdIndex_in with a non-zero dwell
// S_ISSUE | presenting offsets 1..CHUNK_QWS-1 to the buffer RAM
// S_DRAIN | waiting for the last in-flight beat to be accumulated
// S_WAIT  | counting down the remaining dwell
// S_ACK   | dtAck_out high for this single cycle
module consumer_pipe #(
    parameter int CHUNK_QWS  = 16,
    parameter int IDX_W      = 2,
    parameter int RD_LATENCY = 1,
    localparam int OFF_W     = $clog2(CHUNK_QWS)
) (
    input  logic              sysClk_in,
    input  logic              sysRstN_in,
    input  logic [IDX_W-1:0]  wrIndex_in,
    input  logic [IDX_W-1:0]  rdIndex_in,
    output logic              dtAck_out,
    output logic [OFF_W-1:0]  rdOffset_out,
    input  logic [63:0]       rdData_in,
    output logic [63:0]       csData_out,
    output logic              csValid_out,
    input  logic              csReset_in,
    input  logic              csMode_in,
    input  logic [31:0]       countInit_in,
`ifdef CONSUMER_CHUNK_COUNT_EN
    output logic [31:0]       chunkCount_out,
`endif
    output logic              busy_out
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_DRAIN = 3'd2,
        S_WAIT  = 3'd3,
        S_ACK   = 3'd4
    } state_t;

    localparam logic [31:0]      MIN_ACK  = 32'(CHUNK_QWS + RD_LATENCY);
    localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(CHUNK_QWS - 1);

    state_t                 state_q, state_d;
    logic [OFF_W-1:0]       off_q, off_d;
    logic [31:0]            rem_q, rem_d;
    logic                   mode_q, mode_d;
    logic                   dtack_q;
    logic [63:0]            cs_q;
    logic [RD_LATENCY-1:0]  beat_v_q;
    logic [RD_LATENCY-1:0]  last_v_q;

    logic                   start;
    logic                   issue;
    logic                   issue_last;
    logic                   beat;
    logic                   last_beat;
    logic [31:0]            ack_target;

    assign start      = (state_q == S_IDLE) && (countInit_in != 32'd0) &&
                        (wrIndex_in != rdIndex_in);
    assign issue      = start || (state_q == S_ISSUE);
    assign issue_last = (state_q == S_ISSUE) && (off_q == LAST_OFF);
    assign beat       = beat_v_q[RD_LATENCY-1];
    assign last_beat  = last_v_q[RD_LATENCY-1];
    // The ack can never come before the last beat has landed.
    assign ack_target = (countInit_in > MIN_ACK) ? countInit_in : MIN_ACK;

    // Next-state, offset, dwell countdown and mode latch.
    always_comb begin
        state_d = state_q;
        off_d   = off_q;
        rem_d   = rem_q;
        mode_d  = mode_q;
        // rem_q holds (ack cycle - current cycle) while busy
        if (state_q != S_IDLE && rem_q != 32'd0) begin
            rem_d = rem_q - 32'd1;
        end
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ISSUE;
                    off_d   = OFF_W'(1);
                    rem_d   = ack_target - 32'd1;
                    mode_d  = csMode_in;
                end
            end
            S_ISSUE: begin
                if (off_q == LAST_OFF) begin
                    off_d   = '0;
                    state_d = S_DRAIN;
                end else begin
                    off_d = off_q + OFF_W'(1);
                end
            end
            S_DRAIN: begin
                if (last_beat) begin
                    state_d = (rem_q <= 32'd1) ? S_ACK : S_WAIT;
                end
            end
            S_WAIT: begin
                if (rem_q <= 32'd1) begin
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM state, offset, countdown and registered ack pulse.
    always_ff @(posedge sysClk_in or negedge sysRstN_in) begin
        if (!sysRstN_in) begin
            state_q <= S_IDLE;
            off_q   <= '0;
            rem_q   <= '0;
            mode_q  <= 1'b0;
            dtack_q <= 1'b0;
        end else begin
            state_q <= state_d;
            off_q   <= off_d;
            rem_q   <= rem_d;
            mode_q  <= mode_d;
            dtack_q <= (state_d == S_ACK);
        end
    end

    // Beat pipe: tracks which RAM responses belong to the current chunk.
    always_ff @(posedge sysClk_in or negedge sysRstN_in) begin
        if (!sysRstN_in) begin
            beat_v_q <= '0;
            last_v_q <= '0;
        end else begin
            beat_v_q[0] <= issue;
            last_v_q[0] <= issue_last;
            for (int i = 1; i < RD_LATENCY; i++) begin
                beat_v_q[i] <= beat_v_q[i-1];
                last_v_q[i] <= last_v_q[i-1];
            end
        end
    end

    // Checksum accumulator; a clear drops any beat landing in the same cycle.
    always_ff @(posedge sysClk_in or negedge sysRstN_in) begin
        if (!sysRstN_in) begin
            cs_q <= '0;
        end else if (csReset_in) begin
            cs_q <= '0;
        end else if (beat) begin
            cs_q <= mode_q ? (cs_q ^ rdData_in) : (cs_q + rdData_in);
        end
    end

`ifdef CONSUMER_CHUNK_COUNT_EN
    logic [31:0] chunk_cnt_q;

    // Consumed-chunk counter, bumped the cycle after each ack.
    always_ff @(posedge sysClk_in or negedge sysRstN_in) begin
        if (!sysRstN_in) begin
            chunk_cnt_q <= '0;
        end else if (csReset_in) begin
            chunk_cnt_q <= '0;
        end else if (dtack_q) begin
            chunk_cnt_q <= chunk_cnt_q + 32'd1;
        end
    end

    assign chunkCount_out = chunk_cnt_q;
`endif

    assign dtAck_out    = dtack_q;
    assign rdOffset_out = off_q;
    assign csData_out   = cs_q;
    assign busy_out     = (state_q != S_IDLE);
    assign csValid_out  = (state_q == S_IDLE) && (wrIndex_in == rdIndex_in);

endmodule

// File: tb/tb_consumer_pipe.sv
// Bench for consumer_pipe: instance A uses RD_LATENCY=1, instance B RD_LATENCY=3.
// Expected ack cycle and checksum of every chunk are queued before the chunk starts
// and popped when the ack pulse is seen.
module tb_consumer_pipe;

    logic        clk = 1'b0;
    logic        rstA_n, rstB_n;
    logic [1:0]  wr_idx, rd_idx;
    logic        cs_reset, cs_mode;
    logic [31:0] count_init;

    logic        ackA, ackB, csvA, csvB, busyA, busyB;
    logic [3:0]  offA, offB;
    logic [63:0] csA, csB, dataA, dataB;
`ifdef CONSUMER_CHUNK_COUNT_EN
    logic [31:0] ccA, ccB;
`endif

    logic [63:0] qw [16];
    logic [3:0]  histA;
    logic [3:0]  histB [3];

    typedef struct {
        int          ack_cycle;
        logic [63:0] cs;
    } exp_t;
    exp_t sb[$];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    consumer_pipe #(.CHUNK_QWS(16), .IDX_W(2), .RD_LATENCY(1)) u_dut_a (
        .sysClk_in    (clk),
        .sysRstN_in   (rstA_n),
        .wrIndex_in   (wr_idx),
        .rdIndex_in   (rd_idx),
        .dtAck_out    (ackA),
        .rdOffset_out (offA),
        .rdData_in    (dataA),
        .csData_out   (csA),
        .csValid_out  (csvA),
        .csReset_in   (cs_reset),
        .csMode_in    (cs_mode),
        .countInit_in (count_init),
`ifdef CONSUMER_CHUNK_COUNT_EN
        .chunkCount_out (ccA),
`endif
        .busy_out     (busyA)
    );

    consumer_pipe #(.CHUNK_QWS(16), .IDX_W(2), .RD_LATENCY(3)) u_dut_b (
        .sysClk_in    (clk),
        .sysRstN_in   (rstB_n),
        .wrIndex_in   (wr_idx),
        .rdIndex_in   (rd_idx),
        .dtAck_out    (ackB),
        .rdOffset_out (offB),
        .rdData_in    (dataB),
        .csData_out   (csB),
        .csValid_out  (csvB),
        .csReset_in   (cs_reset),
        .csMode_in    (cs_mode),
        .countInit_in (count_init),
`ifdef CONSUMER_CHUNK_COUNT_EN
        .chunkCount_out (ccB),
`endif
        .busy_out     (busyB)
    );

    // Buffer RAM models with 1- and 3-cycle read latency.
    always @(posedge clk) begin
        histA    <= offA;
        histB[0] <= offB;
        histB[1] <= histB[0];
        histB[2] <= histB[1];
    end
    assign dataA = qw[histA];
    assign dataB = qw[histB[2]];

    function automatic logic f_ack(input bit b);
        return b ? ackB : ackA;
    endfunction
    function automatic logic [3:0] f_off(input bit b);
        return b ? offB : offA;
    endfunction
    function automatic logic [63:0] f_cs(input bit b);
        return b ? csB : csA;
    endfunction
    function automatic logic f_busy(input bit b);
        return b ? busyB : busyA;
    endfunction
    function automatic logic f_csv(input bit b);
        return b ? csvB : csvA;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fill_qw(input bit ones);
        for (int i = 0; i < 16; i++) qw[i] = ones ? 64'hFFFF_FFFF_FFFF_FFFF : 64'(i + 1);
    endtask

    task automatic clear_cs(input bit b);
        @(negedge clk);
        cs_reset = 1'b1;
        @(negedge clk);
        cs_reset = 1'b0;
        check("cs_cleared", f_cs(b), 64'd0);
    endtask

    // Runs one chunk whose cycle 0 is the current cycle; caller drives inputs just after a posedge.
    task automatic run_chunk(input bit b, input int csr_cycle, input string tag);
        exp_t        e;
        int          got;
        int          extra;
        logic [63:0] cs_at;
        got   = -1;
        cs_at = '0;
        for (int c = 0; c < 200 && got < 0; c++) begin
            @(negedge clk);
            if (c < 16) check({tag, "_offset"}, 64'(f_off(b)), 64'(c));
            cs_reset = (c == csr_cycle);
            if (f_ack(b)) begin
                got    = c;
                cs_at  = f_cs(b);
                rd_idx = wr_idx;
            end
        end
        cs_reset = 1'b0;
        if (sb.size() == 0) begin
            e.ack_cycle = -2;
            e.cs        = '1;
        end else begin
            e = sb.pop_front();
        end
        check({tag, "_ack_cycle"}, 64'(got), 64'(e.ack_cycle));
        check({tag, "_csdata"}, cs_at, e.cs);
        extra = 0;
        repeat (5) begin
            @(negedge clk);
            if (f_ack(b)) extra++;
        end
        check({tag, "_ack_single"}, 64'(extra), 64'd0);
        check({tag, "_idle_busy"}, 64'(f_busy(b)), 64'd0);
        check({tag, "_idle_csvalid"}, 64'(f_csv(b)), 64'd1);
    endtask

    initial begin
        int   seen_busy;
        int   seen_ack;
        int   seen_off;
        exp_t e;

        rstA_n     = 1'b0;
        rstB_n     = 1'b0;
        wr_idx     = 2'd0;
        rd_idx     = 2'd0;
        cs_reset   = 1'b0;
        cs_mode    = 1'b0;
        count_init = 32'd0;
        fill_qw(1'b0);

        // Reset values with equal indices
        repeat (3) @(negedge clk);
        check("rst_ack", 64'(ackA), 64'd0);
        check("rst_offset", 64'(offA), 64'd0);
        check("rst_csdata", csA, 64'd0);
        check("rst_busy", 64'(busyA), 64'd0);
        check("rst_csvalid", 64'(csvA), 64'd1);
        rstA_n = 1'b1;
        repeat (2) @(negedge clk);

        // Long dwell, incrementing data
        @(posedge clk); #1;
        count_init = 32'd40;
        wr_idx     = 2'd1;
        e.ack_cycle = 40; e.cs = 64'd136; sb.push_back(e);
        run_chunk(1'b0, -1, "dwell40");

        // Short dwell clamps to CHUNK_QWS + RD_LATENCY
        clear_cs(1'b0);
        @(posedge clk); #1;
        count_init = 32'd5;
        wr_idx     = 2'd2;
        e.ack_cycle = 17; e.cs = 64'd136; sb.push_back(e);
        run_chunk(1'b0, -1, "dwell5");

        // Zero dwell never starts a chunk
        @(posedge clk); #1;
        count_init = 32'd0;
        wr_idx     = 2'd3;
        seen_busy = 0; seen_ack = 0; seen_off = 0;
        repeat (30) begin
            @(negedge clk);
            if (busyA) seen_busy++;
            if (ackA) seen_ack++;
            if (offA != 4'd0) seen_off++;
        end
        check("zero_busy", 64'(seen_busy), 64'd0);
        check("zero_ack", 64'(seen_ack), 64'd0);
        check("zero_reads", 64'(seen_off), 64'd0);
        check("zero_csvalid", 64'(csvA), 64'd0);
        rd_idx = 2'd3;

        // XOR of sixteen all-ones words, with index wrap 3 -> 0
        clear_cs(1'b0);
        fill_qw(1'b1);
        @(posedge clk); #1;
        cs_mode    = 1'b1;
        count_init = 32'd5;
        wr_idx     = 2'd0;
        e.ack_cycle = 17; e.cs = 64'd0; sb.push_back(e);
        run_chunk(1'b0, -1, "xor_ones");

        // Sum of sixteen all-ones words wraps
        clear_cs(1'b0);
        @(posedge clk); #1;
        cs_mode = 1'b0;
        wr_idx  = 2'd1;
        e.ack_cycle = 17; e.cs = 64'hFFFF_FFFF_FFFF_FFF0; sb.push_back(e);
        run_chunk(1'b0, -1, "sum_wrap");

        // Checksum clear on cycle 8 drops beats 0..7
        clear_cs(1'b0);
        fill_qw(1'b0);
        @(posedge clk); #1;
        count_init = 32'd40;
        wr_idx     = 2'd2;
        e.ack_cycle = 40; e.cs = 64'd100; sb.push_back(e);
        run_chunk(1'b0, 8, "csreset");

        // Latency-3 instance: abort mid-chunk by reset, then restart across the index wrap
        rstA_n = 1'b0;
        @(negedge clk);
        rstB_n = 1'b1;
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        wr_idx = 2'd3;
        repeat (11) @(negedge clk);
        check("abort_busy_before", 64'(busyB), 64'd1);
        rstB_n = 1'b0;
        #1;
        check("abort_busy", 64'(busyB), 64'd0);
        check("abort_offset", 64'(offB), 64'd0);
        check("abort_csdata", csB, 64'd0);
        check("abort_ack", 64'(ackB), 64'd0);
        rd_idx = 2'd3;
        wr_idx = 2'd0;
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        rstB_n = 1'b1;
        e.ack_cycle = 40; e.cs = 64'd136; sb.push_back(e);
        run_chunk(1'b1, -1, "lat3_restart");

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
